// File: rtl/nios_system_sensor_in_if.sv
// Avalon-MM slave bus bundle for the sensor input port.
// The bench or interconnect drives the master side; the port drives readdata.
interface nios_system_sensor_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/nios_system_sensor_in.sv
// Debounced, edge-capturing sensor input port with a PIO-compatible register map.
// Each line: two-flop synchroniser, persistence counter, then edge capture into a RW1C register.
module nios_system_sensor_in #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  nios_system_sensor_in_if.slave bus,
  input  logic [WIDTH-1:0]       in_port,
  output logic                   irq
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] clr;
  logic [CW-1:0]    cnt [WIDTH];
  logic             wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

  // An accept happens on the cycle the counter has already seen DEBOUNCE_CYCLES-1 differing samples.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (s2[i] != deb[i]) && (cnt[i] == CNT_LAST);
    end
  end

  always_comb begin
    edge_set = '0;
    if (EDGE_TYPE == 0)      edge_set = accept & s2;
    else if (EDGE_TYPE == 1) edge_set = accept & ~s2;
    else                     edge_set = accept;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign wr  = bus.chipselect & ~bus.write_n;
  assign clr = (wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

  // Set is OR-ed in after the clear so a coincident edge is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask     <= '0;
      edgecapture <= '0;
    end else begin
      if (wr && bus.address == 2'd2) irqmask <= bus.writedata[WIDTH-1:0];
      edgecapture <= (edgecapture & ~clr) | edge_set;
    end
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      2'd0:    bus.readdata = 32'(deb);
      2'd2:    bus.readdata = 32'(irqmask);
      2'd3:    bus.readdata = 32'(edgecapture);
      default: bus.readdata = '0;
    endcase
  end

  assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_nios_system_sensor_in.sv
// Directed bench for the sensor input port: two instances (rising-only and any-edge) share stimulus
// and are compared every cycle against a history-window model, plus hand-computed checkpoints.
`timescale 1ns/1ps
module tb_nios_system_sensor_in;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        cs = 1'b0;
  logic        wn = 1'b1;
  logic [31:0] wd = 32'd0;
  logic [3:0]  in_port = 4'hF;
  logic        irq0;
  logic        irq2;

  int n_vec = 0;
  int n_err = 0;

  nios_system_sensor_in_if bus0 ();
  nios_system_sensor_in_if bus2 ();

  assign bus0.address = address;
  assign bus0.chipselect = cs;
  assign bus0.write_n = wn;
  assign bus0.writedata = wd;
  assign bus2.address = address;
  assign bus2.chipselect = cs;
  assign bus2.write_n = wn;
  assign bus2.writedata = wd;

  nios_system_sensor_in #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) u_e0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_port), .irq(irq0));
  nios_system_sensor_in #(.WIDTH(4), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) u_e2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in_port), .irq(irq2));

  initial forever #5 clk = ~clk;

  // Model: hist[j] is the raw input sampled j edges ago. A line is accepted when every
  // synchronised sample in the last D cycles (hist[2..D+1]) disagrees with the debounced level.
  logic [3:0] hist [0:D+1];
  logic [3:0] deb_m, mask_m, ec_m0, ec_m2, acc_m, clr_m;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      for (int j = 0; j <= D + 1; j++) hist[j] = 4'h0;
      deb_m = 4'h0; mask_m = 4'h0; ec_m0 = 4'h0; ec_m2 = 4'h0;
    end else begin
      for (int j = D + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = in_port;
      acc_m = 4'hF;
      for (int j = 2; j <= D + 1; j++) acc_m = acc_m & (hist[j] ^ deb_m);
      clr_m = (cs && !wn && address == 2'd3) ? wd[3:0] : 4'h0;
      if (cs && !wn && address == 2'd2) mask_m = wd[3:0];
      ec_m0 = (ec_m0 & ~clr_m) | (acc_m & ~deb_m);
      ec_m2 = (ec_m2 & ~clr_m) | acc_m;
      deb_m = deb_m ^ acc_m;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [1:0] a, input logic [3:0] ec);
    case (a)
      2'd0:    return {28'd0, deb_m};
      2'd2:    return {28'd0, mask_m};
      2'd3:    return {28'd0, ec};
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    #2.5;
    chk("cyc_rd_e0", bus0.readdata, exp_rd(address, ec_m0));
    chk("cyc_rd_e2", bus2.readdata, exp_rd(address, ec_m2));
    chk("cyc_irq_e0", {31'd0, irq0}, {31'd0, |(ec_m0 & mask_m)});
    chk("cyc_irq_e2", {31'd0, irq2}, {31'd0, |(ec_m2 & mask_m)});
  end

  task automatic rd(input string nm, input logic [1:0] a, input logic [31:0] e0, input logic [31:0] e2);
    address = a;
    #1;
    chk({nm, "_e0"}, bus0.readdata, e0);
    chk({nm, "_e2"}, bus2.readdata, e2);
  endtask

  task automatic chk_irq(input string nm, input logic e0, input logic e2);
    chk({nm, "_e0"}, {31'd0, irq0}, {31'd0, e0});
    chk({nm, "_e2"}, {31'd0, irq2}, {31'd0, e2});
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d, input logic sel);
    @(negedge clk);
    address = a; cs = sel; wn = 1'b0; wd = d;
    @(negedge clk);
    cs = 1'b0; wn = 1'b1; wd = 32'd0;
  endtask

  initial begin
    // Lines high through reset release: accepted exactly at edge 6 after release.
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    rd("boot_data_edge5", 2'd0, 32'h0, 32'h0);
    @(negedge clk);
    rd("boot_data_edge6", 2'd0, 32'hF, 32'hF);
    rd("boot_ec", 2'd3, 32'hF, 32'hF);

    // Async reset mid-debounce with state present.
    bus_wr(2'd2, 32'hF, 1'b1);
    chk_irq("mask_over_captured", 1'b1, 1'b1);
    in_port = 4'h0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b0;
    rd("rst_a0", 2'd0, 32'h0, 32'h0);
    rd("rst_a1", 2'd1, 32'h0, 32'h0);
    rd("rst_a2", 2'd2, 32'h0, 32'h0);
    rd("rst_a3", 2'd3, 32'h0, 32'h0);
    chk_irq("rst_irq", 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Debounce latency on bit 0, then a too-short pulse on bit 1.
    @(negedge clk);
    in_port = 4'h1;
    repeat (5) @(negedge clk);
    rd("lat_k4", 2'd0, 32'h0, 32'h0);
    @(negedge clk);
    rd("lat_k5", 2'd0, 32'h1, 32'h1);
    in_port = 4'h3;
    repeat (3) @(negedge clk);
    in_port = 4'h1;
    repeat (8) @(negedge clk);
    rd("glitch_data", 2'd0, 32'h1, 32'h1);
    rd("glitch_ec", 2'd3, 32'h1, 32'h1);

    // Interrupt masking and partial clears.
    bus_wr(2'd3, 32'hF, 1'b1);
    bus_wr(2'd2, 32'h2, 1'b1);
    chk_irq("mask2_idle", 1'b0, 1'b0);
    in_port = 4'h3;
    repeat (6) @(negedge clk);
    rd("b1_ec", 2'd3, 32'h2, 32'h2);
    chk_irq("b1_irq", 1'b1, 1'b1);
    bus_wr(2'd3, 32'h1, 1'b1);
    chk_irq("clr_other_irq", 1'b1, 1'b1);
    bus_wr(2'd3, 32'h2, 1'b1);
    rd("clr_b1_ec", 2'd3, 32'h0, 32'h0);
    chk_irq("clr_b1_irq", 1'b0, 1'b0);

    // Clear of bit 2 lands on the edge that accepts it.
    in_port = 4'h7;
    repeat (4) @(negedge clk);
    bus_wr(2'd3, 32'h4, 1'b1);
    rd("collide_ec", 2'd3, 32'h4, 32'h4);
    bus_wr(2'd3, 32'h4, 1'b1);
    rd("clr_b2_ec", 2'd3, 32'h0, 32'h0);

    // Falling edge on bit 3 is captured only by the any-edge instance.
    in_port = 4'hF;
    repeat (7) @(negedge clk);
    rd("b3_rise_ec", 2'd3, 32'h8, 32'h8);
    bus_wr(2'd3, 32'hF, 1'b1);
    in_port = 4'h7;
    repeat (7) @(negedge clk);
    rd("b3_fall_ec", 2'd3, 32'h0, 32'h8);
    rd("b3_fall_data", 2'd0, 32'h7, 32'h7);

    // Register decode.
    bus_wr(2'd0, 32'hFFFF_FFFF, 1'b1);
    bus_wr(2'd1, 32'hFFFF_FFFF, 1'b1);
    rd("dec_a1", 2'd1, 32'h0, 32'h0);
    rd("dec_a0", 2'd0, 32'h7, 32'h7);
    rd("dec_a2", 2'd2, 32'h2, 32'h2);
    rd("dec_a3", 2'd3, 32'h0, 32'h8);
    bus_wr(2'd2, 32'hFFFF_FFF5, 1'b1);
    rd("mask_trunc", 2'd2, 32'h5, 32'h5);
    chk_irq("mask5_irq", 1'b0, 1'b0);
    bus_wr(2'd2, 32'h8, 1'b0);
    rd("no_cs_write", 2'd2, 32'h5, 32'h5);
    bus_wr(2'd2, 32'h8, 1'b1);
    chk_irq("mask8_irq", 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
